w_gen_pp: RTL and testbench

- Double-buffered (ping-pong) weight generator for the PE array, single clock.
- Accepts a stream of BANDWIDTH-bit weight beats into a shadow buffer of NUM_BANK banks while the active buffer feeds the array.
- Buffers swap on layer finish. Read address advances per data_vld_in, with a configurable repeat count.
- Parametrised successor of the single-buffer weight generator: adds write backpressure, a runtime slice length and an explicit swap protocol.

---
 rtl/w_gen_pp.sv | 172 +++++++++++++++++
 tb/tb_w_gen_pp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/w_gen_pp.sv
// Ping-pong weight generator: a shadow buffer fills from a beat stream
// while the active buffer feeds the PE array; buffers swap on layer finish.
module w_gen_pp #(
    parameter int BANDWIDTH = 512,
    parameter int NUM_BANK  = 16,
    parameter int DEPTH     = 256,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                          clk_calc,
    input  logic                          rst,
    input  logic [AW:0]                   cfg_len,
    input  logic [7:0]                    cfg_rep,
    input  logic                          w_in_vld,
    input  logic [BANDWIDTH-1:0]          w_in,
    output logic                          w_in_rdy,
    input  logic                          data_vld_in,
    input  logic                          w_chg_en,
    output logic [BANDWIDTH*NUM_BANK-1:0] w_out,
    output logic                          w_act_vld,
    output logic                          w_load_done,
    output logic                          w_slice_wrap
);

    localparam int BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } wr_state_t;

    wr_state_t state;
    wr_state_t state_nxt;

    logic [BANDWIDTH-1:0] mem [2][NUM_BANK][DEPTH];

    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   shadow_len;
    logic [AW:0]   active_len;
    logic [AW:0]   len_eff;
    logic [AW:0]   fill_len;
    logic [7:0]    rep_eff;
    logic [7:0]    active_rep;
    logic [7:0]    rep_cnt;
    logic [AW-1:0] rd_addr;
    logic          act_sel;
    logic          chg_pend;
    logic          accept;
    logic          last_beat;
    logic          swap_fire;
    logic          rd_step;
    logic          rep_last;
    logic          addr_last;

    // Handshake, fill-completion and swap decisions; zero configs act as 1.
    always_comb begin
        len_eff   = (cfg_len == '0) ? (AW+1)'(1) : cfg_len;
        rep_eff   = (cfg_rep == 8'd0) ? 8'd1 : cfg_rep;
        accept    = w_in_vld & w_in_rdy;
        fill_len  = (state == EMPTY) ? len_eff : shadow_len;
        last_beat = (wr_bank == BW'(NUM_BANK - 1)) &&
                    ({1'b0, wr_addr} == fill_len - 1'b1);
        swap_fire = (w_chg_en | chg_pend) & (state == FULL);
        rd_step   = w_act_vld & data_vld_in & ~swap_fire;
        rep_last  = (rep_cnt == active_rep - 8'd1);
        addr_last = ({1'b0, rd_addr} == active_len - 1'b1);
    end

    // Write FSM next state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (accept) state_nxt = last_beat ? FULL : FILL;
            end
            FILL: begin
                if (accept && last_beat) state_nxt = FULL;
            end
            FULL: begin
                if (swap_fire) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Write FSM state, registered ready and shadow bank/address counters.
    always_ff @(posedge clk_calc) begin
        if (rst) begin
            state      <= EMPTY;
            w_in_rdy   <= 1'b0;
            wr_bank    <= '0;
            wr_addr    <= '0;
            shadow_len <= '0;
        end else begin
            state    <= state_nxt;
            w_in_rdy <= (state_nxt != FULL);
            if (accept) begin
                if (state == EMPTY) shadow_len <= len_eff;
                if (last_beat) begin
                    wr_bank <= '0;
                    wr_addr <= '0;
                end else if (wr_bank == BW'(NUM_BANK - 1)) begin
                    wr_bank <= '0;
                    wr_addr <= wr_addr + 1'b1;
                end else begin
                    wr_bank <= wr_bank + 1'b1;
                end
            end
        end
    end

    // Shadow buffer write; the shadow is always the non-active half.
    always_ff @(posedge clk_calc) begin
        if (accept && !rst) mem[~act_sel][wr_bank][wr_addr] <= w_in;
    end

    // Swap handling and read address / repeat counting.
    always_ff @(posedge clk_calc) begin
        if (rst) begin
            act_sel      <= 1'b0;
            active_len   <= '0;
            active_rep   <= '0;
            rd_addr      <= '0;
            rep_cnt      <= '0;
            chg_pend     <= 1'b0;
            w_act_vld    <= 1'b0;
            w_load_done  <= 1'b0;
            w_slice_wrap <= 1'b0;
        end else begin
            w_load_done  <= swap_fire;
            w_slice_wrap <= 1'b0;
            if (swap_fire) begin
                act_sel    <= ~act_sel;
                active_len <= shadow_len;
                active_rep <= rep_eff;
                rd_addr    <= '0;
                rep_cnt    <= '0;
                chg_pend   <= 1'b0;
                w_act_vld  <= 1'b1;
            end else begin
                if (w_chg_en) chg_pend <= 1'b1;
                if (rd_step) begin
                    if (rep_last) begin
                        rep_cnt <= '0;
                        if (addr_last) begin
                            rd_addr      <= '0;
                            w_slice_wrap <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end else begin
                        rep_cnt <= rep_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // Registered read of the active word across all banks.
    always_ff @(posedge clk_calc) begin
        if (rst) begin
            w_out <= '0;
        end else begin
            for (int i = 0; i < NUM_BANK; i++) begin
                w_out[BANDWIDTH*i +: BANDWIDTH] <=
                    w_act_vld ? mem[act_sel][i][rd_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_w_gen_pp.sv
// Directed bench for w_gen_pp with BANDWIDTH=8, NUM_BANK=4, DEPTH=8.
// Expected words are hand-computed from the beat values sent.
module tb_w_gen_pp;

    localparam int BANDWIDTH = 8;
    localparam int NUM_BANK  = 4;
    localparam int DEPTH     = 8;

    logic        clk_calc = 1'b0;
    logic        rst;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_rep;
    logic        w_in_vld;
    logic [7:0]  w_in;
    logic        w_in_rdy;
    logic        data_vld_in;
    logic        w_chg_en;
    logic [31:0] w_out;
    logic        w_act_vld;
    logic        w_load_done;
    logic        w_slice_wrap;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_calc = ~clk_calc;

    w_gen_pp #(
        .BANDWIDTH(BANDWIDTH),
        .NUM_BANK (NUM_BANK),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_calc    (clk_calc),
        .rst         (rst),
        .cfg_len     (cfg_len),
        .cfg_rep     (cfg_rep),
        .w_in_vld    (w_in_vld),
        .w_in        (w_in),
        .w_in_rdy    (w_in_rdy),
        .data_vld_in (data_vld_in),
        .w_chg_en    (w_chg_en),
        .w_out       (w_out),
        .w_act_vld   (w_act_vld),
        .w_load_done (w_load_done),
        .w_slice_wrap(w_slice_wrap)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_calc);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        w_in_vld = 1'b1;
        w_in     = d;
        tick();
        w_in_vld = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        rst         = 1'b1;
        cfg_len     = 4'd2;
        cfg_rep     = 8'd3;
        w_in_vld    = 1'b0;
        w_in        = 8'h00;
        data_vld_in = 1'b0;
        w_chg_en    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_rdy", w_in_rdy, 0);
        check("rst_wout", w_out, 0);
        check("rst_act", w_act_vld, 0);
        check("rst_done", w_load_done, 0);
        check("rst_wrap", w_slice_wrap, 0);
        rst = 1'b0;
        tick();
        check("rdy_after_rst", w_in_rdy, 1);

        // 1. Fill 8 beats (len 2) then swap
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("rdy_before_last", w_in_rdy, 1);
            beat(8'h10 + 8'(k));
        end
        check("t1_rdy_full", w_in_rdy, 0);
        check("t1_act_pre", w_act_vld, 0);
        w_chg_en = 1'b1;
        tick();
        w_chg_en = 1'b0;
        check("t1_done", w_load_done, 1);
        check("t1_act", w_act_vld, 1);
        check("t1_wout_lat", w_out, 0);
        tick();
        check("t1_wout", w_out, 32'h13121110);
        check("t1_done_clr", w_load_done, 0);
        check("t1_rdy_back", w_in_rdy, 1);

        // 2. Repeat 3, wrap after beat 6
        data_vld_in = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            exp_w = (((j - 1) / 3) % 2 == 1) ? 32'h17161514 : 32'h13121110;
            check($sformatf("t2_wout_%0d", j), w_out, exp_w);
            check($sformatf("t2_wrap_%0d", j), w_slice_wrap, j == 6);
        end
        data_vld_in = 1'b0;

        // 3/4/5. Early request, backpressure, ping-pong, collision
        cfg_len = 4'd1;
        cfg_rep = 8'd2;
        for (int k = 0; k < 4; k++) begin
            w_chg_en = (k == 1);
            beat(8'hA0 + 8'(k));
            w_chg_en = 1'b0;
            if (k < 3) check($sformatf("t3_act_hold_%0d", k), w_load_done, 0);
        end
        check("t3_rdy_full", w_in_rdy, 0);
        check("t4_a_unchanged", w_out, 32'h17161514);
        w_in_vld    = 1'b1;
        w_in        = 8'hEE;
        data_vld_in = 1'b1;
        tick();
        w_in_vld = 1'b0;
        check("t3_done", w_load_done, 1);
        check("t4_rdy_swap", w_in_rdy, 1);
        check("t4_a_swapcyc", w_out, 32'h17161514);
        tick();
        check("t4_wout_b", w_out, 32'hA3A2A1A0);
        check("t5_wrap_b1", w_slice_wrap, 0);
        check("t3_done_clr", w_load_done, 0);
        tick();
        check("t5_wrap_b2", w_slice_wrap, 1);
        check("t4_wout_b2", w_out, 32'hA3A2A1A0);
        data_vld_in = 1'b0;
        tick();

        // 6. Reset mid-fill, fresh fill required
        cfg_len = 4'd2;
        for (int k = 0; k < 5; k++) beat(8'h50 + 8'(k));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_wout", w_out, 0);
        check("t6_act", w_act_vld, 0);
        check("t6_rdy_rst", w_in_rdy, 0);
        check("t6_wrap", w_slice_wrap, 0);
        tick();
        check("t6_rdy", w_in_rdy, 1);
        for (int k = 0; k < 7; k++) beat(8'h60 + 8'(k));
        check("t6_rdy_7", w_in_rdy, 1);
        w_chg_en = 1'b1;
        tick();
        w_chg_en = 1'b0;
        check("t6_no_swap", w_act_vld, 0);
        cfg_rep = 8'd0;
        beat(8'h67);
        check("t6_rdy_full", w_in_rdy, 0);
        check("t6_act_pre", w_act_vld, 0);
        tick();
        check("t6_done", w_load_done, 1);
        check("t6_act_on", w_act_vld, 1);
        tick();
        check("t6_wout0", w_out, 32'h63626160);

        // cfg_rep = 0 behaves as 1
        data_vld_in = 1'b1;
        tick();
        check("rep0_b1_wout", w_out, 32'h63626160);
        check("rep0_b1_wrap", w_slice_wrap, 0);
        tick();
        check("rep0_b2_wout", w_out, 32'h67666564);
        check("rep0_b2_wrap", w_slice_wrap, 1);
        tick();
        check("rep0_b3_wout", w_out, 32'h63626160);
        check("rep0_b3_wrap", w_slice_wrap, 0);
        data_vld_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
